// File: rtl/o_counter_pkg.sv
// Shared widths and default configuration for the receive-side frame counter
// and its ADC sampling-phase watchdog.
package o_counter_pkg;
   localparam int X_W     = 10;
   localparam int Y_W     = 9;
   localparam int VIDEO_W = 10;
   localparam int BAD_W   = 16;

   localparam int DEF_H_START    = 160;
   localparam int DEF_H_LEN      = 128;
   localparam int DEF_V_START    = 32;
   localparam int DEF_V_LEN      = 128;
   localparam int DEF_FRAMES_1HZ = 60;

   localparam int DEF_MID_LO    = 256;
   localparam int DEF_MID_HI    = 767;
   localparam int DEF_BAD_LIMIT = 64;
endpackage

// File: rtl/rx_sync_wd.sv
// ADC phase watchdog: counts visible samples in the mid-level band per frame
// and judges the phase bad at each vsync fall.
module rx_sync_wd
   import o_counter_pkg::*;
#(
   parameter int MID_LO    = DEF_MID_LO,
   parameter int MID_HI    = DEF_MID_HI,
   parameter int BAD_LIMIT = DEF_BAD_LIMIT
) (
   input  logic               O_CLK,
   input  logic               RST_N,
   input  logic               VISIBLE,
   input  logic [VIDEO_W-1:0] VIDEO,
   input  logic               VSYNC,
   output logic               SYNC_BAD
);
   localparam logic [VIDEO_W-1:0] LO    = VIDEO_W'(MID_LO);
   localparam logic [VIDEO_W-1:0] HI    = VIDEO_W'(MID_HI);
   localparam logic [BAD_W-1:0]   LIMIT = BAD_W'(BAD_LIMIT);

   logic             vs_d;
   logic [BAD_W-1:0] mid_cnt;
   logic             vs_fall;
   logic             in_band;

   function automatic logic [BAD_W-1:0] sat_inc(input logic [BAD_W-1:0] v);
      return (&v) ? v : v + BAD_W'(1);
   endfunction

   assign vs_fall = vs_d & ~VSYNC;
   assign in_band = (VIDEO >= LO) && (VIDEO <= HI);

   // The sample coinciding with the vsync fall is dropped so the verdict
   // reflects only the frame that just ended.
   always_ff @(posedge O_CLK or negedge RST_N) begin
      if (!RST_N) begin
         vs_d     <= 1'b1;
         mid_cnt  <= '0;
         SYNC_BAD <= 1'b0;
      end else begin
         vs_d <= VSYNC;
         if (vs_fall) begin
            SYNC_BAD <= (mid_cnt > LIMIT);
            mid_cnt  <= '0;
         end else if (VISIBLE && in_band) begin
            mid_cnt <= sat_inc(mid_cnt);
         end
      end
   end
endmodule

// File: rtl/o_counter_sync_wd.sv
// Receive-side pixel/line position counter with capture window, TX resync and
// 1 Hz pulses. Define RX_SYNC_WD_EN to compile in the ADC phase watchdog.
module o_counter_sync_wd
   import o_counter_pkg::*;
#(
   parameter int H_START    = DEF_H_START,
   parameter int H_LEN      = DEF_H_LEN,
   parameter int V_START    = DEF_V_START,
   parameter int V_LEN      = DEF_V_LEN,
   parameter int FRAMES_1HZ = DEF_FRAMES_1HZ,
   parameter int MID_LO     = DEF_MID_LO,
   parameter int MID_HI     = DEF_MID_HI,
   parameter int BAD_LIMIT  = DEF_BAD_LIMIT
) (
   input  logic               O_CLK,
   input  logic               RST_N,
   input  logic               ENABLE,
   input  logic               O_HS,
   input  logic               O_VS,
   input  logic [VIDEO_W-1:0] VIDEO,
   output logic [X_W-1:0]     O_X,
   output logic [Y_W-1:0]     O_Y,
   output logic               O_VISIBLE,
   output logic               PULSE_1HZ,
   output logic               SYNC,
   output logic               O_SYNC_BAD
);
   localparam int FC_W = (FRAMES_1HZ > 1) ? $clog2(FRAMES_1HZ) : 1;
   // Window bounds carry one extra bit so an end bound of 2**W still compares.
   localparam logic [X_W:0]    X_LO    = (X_W+1)'(H_START);
   localparam logic [X_W:0]    X_HI    = (X_W+1)'(H_START + H_LEN);
   localparam logic [Y_W:0]    Y_LO    = (Y_W+1)'(V_START);
   localparam logic [Y_W:0]    Y_HI    = (Y_W+1)'(V_START + V_LEN);
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_1HZ - 1);

   logic            hs_d;
   logic            vs_d;
   logic            hs_fall;
   logic            vs_fall;
   logic            vs_rise;
   logic [FC_W-1:0] frame_cnt;

   function automatic logic [X_W-1:0] sat_inc_x(input logic [X_W-1:0] v);
      return (&v) ? v : v + X_W'(1);
   endfunction

   function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] v);
      return (&v) ? v : v + Y_W'(1);
   endfunction

   assign hs_fall = hs_d & ~O_HS;
   assign vs_fall = vs_d & ~O_VS;
   assign vs_rise = ~vs_d & O_VS;

   always_ff @(posedge O_CLK or negedge RST_N) begin
      if (!RST_N) begin
         hs_d      <= 1'b1;
         vs_d      <= 1'b1;
         O_X       <= '0;
         O_Y       <= '0;
         SYNC      <= 1'b0;
         PULSE_1HZ <= 1'b0;
         frame_cnt <= '0;
      end else begin
         hs_d <= O_HS;
         vs_d <= O_VS;

         if (!O_HS || !ENABLE) O_X <= '0;
         else                  O_X <= sat_inc_x(O_X);

         // A low vsync level already holds the line count at zero.
         if (!O_VS || !ENABLE) O_Y <= '0;
         else if (hs_fall)     O_Y <= sat_inc_y(O_Y);

         SYNC      <= ENABLE & vs_rise;
         PULSE_1HZ <= 1'b0;
         if (ENABLE && vs_fall) begin
            if (frame_cnt == FC_LAST) begin
               frame_cnt <= '0;
               PULSE_1HZ <= 1'b1;
            end else begin
               frame_cnt <= frame_cnt + FC_W'(1);
            end
         end
      end
   end

   assign O_VISIBLE = ENABLE
                      && ({1'b0, O_X} >= X_LO) && ({1'b0, O_X} < X_HI)
                      && ({1'b0, O_Y} >= Y_LO) && ({1'b0, O_Y} < Y_HI);

`ifdef RX_SYNC_WD_EN
   rx_sync_wd #(
      .MID_LO    (MID_LO),
      .MID_HI    (MID_HI),
      .BAD_LIMIT (BAD_LIMIT)
   ) u_wd (
      .O_CLK    (O_CLK),
      .RST_N    (RST_N),
      .VISIBLE  (O_VISIBLE),
      .VIDEO    (VIDEO),
      .VSYNC    (O_VS),
      .SYNC_BAD (O_SYNC_BAD)
   );
`else
   logic unused_wd;
   assign unused_wd  = ^{VIDEO, MID_LO, MID_HI, BAD_LIMIT};
   assign O_SYNC_BAD = 1'b0;
`endif
endmodule

// File: tb/tb_o_counter_sync_wd.sv
// Scoreboard bench for o_counter_sync_wd: a frame-level reference model queues
// expected outputs per clock, a monitor pops and compares them.
module tb_o_counter_sync_wd;
`ifdef RX_SYNC_WD_EN
   localparam bit WD_ON = 1'b1;
`else
   localparam bit WD_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       hs = 1'b1;
   logic       vs = 1'b1;
   logic [9:0] video = '0;
   logic [9:0] x;
   logic [8:0] y;
   logic       vis, p1hz, sync, bad;

   always #5 clk = ~clk;

   o_counter_sync_wd dut (
      .O_CLK      (clk),
      .RST_N      (rst_n),
      .ENABLE     (en),
      .O_HS       (hs),
      .O_VS       (vs),
      .VIDEO      (video),
      .O_X        (x),
      .O_Y        (y),
      .O_VISIBLE  (vis),
      .PULSE_1HZ  (p1hz),
      .SYNC       (sync),
      .O_SYNC_BAD (bad)
   );

   typedef struct packed {
      logic [9:0] x;
      logic [8:0] y;
      logic       vis;
      logic       pulse;
      logic       sync;
      logic       bad;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;

   // reference model state
   int m_x, m_y, m_frame, m_mid;
   bit m_hsd = 1, m_vsd = 1, m_sync, m_pulse, m_bad;

   // observation tallies for directed checks
   int cnt_vis = 0, cnt_vis_rise = 0, cnt_sync = 0, cnt_pulse = 0, max_x = 0;
   bit prev_vis = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit win(input int xx, input int yy);
      return (xx >= 160) && (xx < 160 + 128) && (yy >= 32) && (yy < 32 + 128);
   endfunction

   function automatic int oob();
      return ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 255))
                                         : int'($urandom_range(768, 1023));
   endfunction

   task automatic model_step();
      exp_t e;
      bit   hf, vf, vr, vis_cur;
      if (!rst_n) begin
         m_x = 0; m_y = 0; m_frame = 0; m_mid = 0;
         m_hsd = 1; m_vsd = 1; m_sync = 0; m_pulse = 0; m_bad = 0;
      end else begin
         vis_cur = en && win(m_x, m_y);
         hf = m_hsd && !hs;
         vf = m_vsd && !vs;
         vr = !m_vsd && vs;
         m_x = (!hs || !en) ? 0 : ((m_x < 1023) ? m_x + 1 : 1023);
         if (!vs || !en) m_y = 0;
         else if (hf && m_y < 511) m_y = m_y + 1;
         m_sync  = en && vr;
         m_pulse = 0;
         if (en && vf) begin
            m_frame = m_frame + 1;
            if (m_frame == 60) begin
               m_frame = 0;
               m_pulse = 1;
            end
         end
         if (WD_ON) begin
            if (vf) begin
               m_bad = (m_mid > 64);
               m_mid = 0;
            end else if (vis_cur && video >= 256 && video <= 767 && m_mid < 65535) begin
               m_mid = m_mid + 1;
            end
         end
         m_hsd = hs;
         m_vsd = vs;
      end
      e.x     = 10'(m_x);
      e.y     = 9'(m_y);
      e.vis   = en && win(m_x, m_y);
      e.pulse = m_pulse;
      e.sync  = m_sync;
      e.bad   = m_bad;
      sb.push_back(e);
   endtask

   task automatic step(input bit r, input bit h, input bit v, input bit e, input int vid);
      @(negedge clk);
      rst_n = r;
      hs    = h;
      vs    = v;
      en    = e;
      video = 10'(vid);
      model_step();
   endtask

   task automatic clear_tallies();
      cnt_vis = 0; cnt_vis_rise = 0; cnt_sync = 0; cnt_pulse = 0; max_x = 0;
   endtask

   task automatic do_reset();
      for (int i = 0; i < 4; i++)
         step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1023));
      step(1, 1, 1, 1, 0);
   endtask

   task automatic short_line(input bit v, input int high_len);
      step(1, 0, v, 1, oob());
      for (int i = 0; i < high_len; i++) step(1, 1, v, 1, oob());
   endtask

   task automatic vs_frame(input bit e);
      step(1, 1, 0, e, 0);
      step(1, 1, 0, e, 0);
      step(1, 1, 1, e, 0);
      step(1, 1, 1, e, 0);
   endtask

   // One frame with n_mid in-band visible samples, then a vsync fall.
   task automatic wd_frame(input int n_mid, input bit ext, input bit fall_in_win,
                           input bit exp_bad, input string name);
      int issued;
      bit done;
      issued = 0;
      done   = 0;
      for (int i = 0; i < 33; i++) short_line(1, 1);
      step(1, 0, 1, 1, oob());
      for (int i = 0; i < 300 && !done; i++) begin
         if (fall_in_win && issued == n_mid && win(m_x, m_y)) done = 1;
         else if (!ext && issued < n_mid && win(m_x, m_y)) begin
            step(1, 1, 1, 1, 512);
            issued++;
         end else begin
            step(1, 1, 1, 1, ext ? (($urandom_range(0, 1) != 0) ? 0 : 1023) : oob());
         end
      end
      step(1, 1, 0, 1, 512);
      step(1, 1, 0, 1, 0);
      check(name, int'(bad), (WD_ON && exp_bad) ? 1 : 0);
      step(1, 1, 1, 1, 0);
      step(1, 1, 1, 1, 0);
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("o_x", int'(x), int'(e.x));
            check("o_y", int'(y), int'(e.y));
            check("o_visible", int'(vis), int'(e.vis));
            check("pulse_1hz", int'(p1hz), int'(e.pulse));
            check("sync", int'(sync), int'(e.sync));
            check("o_sync_bad", int'(bad), int'(e.bad));
         end
         if (vis) cnt_vis++;
         if (vis && !prev_vis) cnt_vis_rise++;
         prev_vis = vis;
         if (sync) cnt_sync++;
         if (p1hz) cnt_pulse++;
         if (int'(x) > max_x) max_x = int'(x);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got 0 completions, expected 1");
      $fatal(1, "time limit expired");
   end

   // stimulus
   initial begin
      bit rh, rv, re, rr;
      // reset with random inputs
      for (int i = 0; i < 8; i++)
         step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1023));
      step(1, 1, 1, 1, 0);

      // single line at O_Y = 32
      for (int i = 0; i < 31; i++) short_line(1, 1);
      for (int i = 0; i < 10; i++) step(1, 0, 1, 1, oob());
      clear_tallies();
      for (int i = 0; i < 300; i++) step(1, 1, 1, 1, oob());
      step(1, 0, 1, 1, oob());
      check("line_visible_clocks", cnt_vis, 128);
      check("line_max_x", max_x, 300);

      // 200 lines, then a vsync pulse
      do_reset();
      clear_tallies();
      for (int i = 0; i < 200; i++) short_line(1, 170);
      check("frame_o_y", int'(y), 200);
      check("frame_visible_lines", cnt_vis_rise, 128);
      clear_tallies();
      for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0);
      check("sync_pulses", cnt_sync, 1);

      // 1 Hz divider
      do_reset();
      clear_tallies();
      for (int i = 0; i < 59; i++) vs_frame(1);
      check("pulse_before_60", cnt_pulse, 0);
      vs_frame(1);
      check("pulse_on_60", cnt_pulse, 1);
      clear_tallies();
      for (int i = 0; i < 60; i++) vs_frame(0);
      check("pulse_disabled", cnt_pulse, 0);

      // watchdog
      do_reset();
      wd_frame(65, 0, 0, 1, "wd_65_mid");
      wd_frame(0, 1, 0, 0, "wd_extremes");
      wd_frame(65, 0, 0, 1, "wd_65_again");
      wd_frame(64, 0, 0, 0, "wd_64_mid");
      wd_frame(64, 0, 1, 0, "wd_fall_on_sample");

      // saturation of both counters
      for (int i = 0; i < 1100; i++) step(1, 1, 1, 1, oob());
      check("x_saturated", int'(x), 1023);
      for (int i = 0; i < 520; i++) short_line(1, 1);
      check("y_saturated", int'(y), 511);
      step(1, 0, 1, 1, 0);
      step(1, 0, 0, 1, 0);

      // random traffic with occasional mid-frame reset
      rh = 1; rv = 1; re = 1;
      for (int i = 0; i < 3000; i++) begin
         rr = ($urandom_range(0, 499) != 0);
         if ($urandom_range(0, 19) == 0) rh = ~rh;
         if ($urandom_range(0, 199) == 0) rv = ~rv;
         if ($urandom_range(0, 299) == 0) re = ~re;
         step(rr, rh, rv, re, $urandom_range(0, 1023));
      end

      @(posedge clk);
      #2;
      check("scoreboard_drain", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/o_counter_sync_wd.md
# o_counter_sync_wd

Receive-side frame position counter with an ADC sampling-phase watchdog, clocked by the incoming pixel clock. It tracks pixel X/Y from the incoming HP active-low syncs and flags the visible capture window that drives BRAM writes. It emits a TX resynchronisation pulse and a once-per-second pulse, and raises `O_SYNC_BAD` when too many visible samples land mid-transition.

## Interface
- `H_START`, 160: first visible `O_X` value.
- `H_LEN`, 128: visible pixels per line.
- `V_START`, 32: first visible `O_Y` value.
- `V_LEN`, 128: visible lines; H_LEN*V_LEN ≤ 16384, the 14-bit BRAM space.
- `FRAMES_1HZ`, 60: frames per `PULSE_1HZ`.
- `MID_LO`, 256: lower bound of the invalid mid-level band, inclusive.
- `MID_HI`, 767: upper bound of the invalid mid-level band, inclusive.
- `BAD_LIMIT`, 64: mid-band samples per frame tolerated.
- `O_CLK` in 1: pixel clock; the only clock.
- `RST_N` in 1: asynchronous, active-low reset.
- `ENABLE` in 1: active-high counter enable.
- `O_HS` in 1: incoming hsync, active low.
- `O_VS` in 1: incoming vsync, active low.
- `VIDEO` in 10: ADC sample.
- `O_X` out 10: pixel counter.
- `O_Y` out 9: line counter.
- `O_VISIBLE` out 1: inside the capture window.
- `PULSE_1HZ` out 1: one-cycle pulse every FRAMES_1HZ frames.
- `SYNC` out 1: one-cycle pulse at end of vsync.
- `O_SYNC_BAD` out 1: ADC phase judged bad for the last frame.

## Operation
- Reset values:
  - `O_X`, `O_Y`, frame counter, mid-band counter = 0.
  - `SYNC`, `PULSE_1HZ`, `O_SYNC_BAD` = 0.
  - The `hs_d`/`vs_d` edge registers = 1.
- Edge detection uses `hs_d`/`vs_d`, which hold the previous `O_HS`/`O_VS`.
  - HS fall: `hs_d`=1, `O_HS`=0. VS fall and VS rise follow the same pattern on `O_VS`.
- `O_X`:
  - 0 while `O_HS`=0 or `ENABLE`=0.
  - Otherwise +1 per clock, saturating at 1023.
- `O_Y`:
  - 0 while `O_VS`=0 or `ENABLE`=0.
  - Otherwise +1 on each HS fall, saturating at 511.
- `O_VISIBLE` (combinational from registered counters) = `ENABLE` & H_START ≤ `O_X` < H_START+H_LEN & V_START ≤ `O_Y` < V_START+V_LEN.
- `SYNC` = 1 for exactly the cycle after a VS rise is detected, and only when `ENABLE`=1.
- Frame counter:
  - Advances on each VS fall when `ENABLE`=1.
  - At FRAMES_1HZ-1 it wraps to 0 and `PULSE_1HZ` is 1 for one cycle.
  - Held while `ENABLE`=0.
- Watchdog mid-band counter (16-bit, saturating):
  - +1 each cycle with `O_VISIBLE`=1 and MID_LO ≤ `VIDEO` ≤ MID_HI.
  - On VS fall: `O_SYNC_BAD` ← (count > BAD_LIMIT), and the count clears to 0 in the same cycle.
  - `O_SYNC_BAD` holds between VS falls.
- Simultaneous events:
  - VS fall coinciding with a qualifying sample: the sample is not counted, so evaluation sees the pre-edge count.
  - HS fall while `O_VS`=0: no `O_Y` increment.
- `RST_N` asserted mid-frame: all state returns to reset values immediately. Counting resumes from the next HS/VS levels.

## Timing
- Every output is registered, except `O_VISIBLE`, which is a combinational compare of registered counters.
- `O_X` is 1 on the first clock after `O_HS` is sampled high. `O_X` = k on the k-th high cycle.
- `O_Y` updates one clock after the HS fall is sampled.
- `SYNC`, `PULSE_1HZ`, and the `O_SYNC_BAD` update each appear one clock after the relevant edge is sampled.
- No handshakes; no backpressure.

## Configuration
- `RX_SYNC_WD_EN` defined: watchdog compiled in as specified.
- Not defined: watchdog logic removed; `O_SYNC_BAD` tied to 0.
- MID_LO/MID_HI/BAD_LIMIT remain declared but unused when the macro is not defined.

## Structure
- Package `o_counter_pkg` holds:
  - the default window constants (H_START/H_LEN/V_START/V_LEN);
  - the FRAMES_1HZ default;
  - the watchdog threshold defaults;
  - the X/Y width localparams (10/9).
- Sub-module `rx_sync_wd` contains the watchdog: `O_CLK`, `RST_N`, `VISIBLE`, `VIDEO`, `VSYNC` in; `SYNC_BAD` out.
  - Instantiated under `RX_SYNC_WD_EN`.
- Top holds counters, edge detect, frame divider.

## Test plan
- Reset: `RST_N`=0 with random inputs → `O_X`=0, `O_Y`=0, `SYNC`=0, `PULSE_1HZ`=0, `O_SYNC_BAD`=0.
- Line: `O_VS`=1, `O_HS` low 10 clocks then high 300 clocks.
  - `O_X` counts 1..300.
  - With `O_Y`=32, `O_VISIBLE` is high for exactly 128 clocks (`O_X` 160..287).
- Frame: 200 HS falls with `O_VS`=1 → `O_Y`=200 and the count of visible lines is 128. Then VS rise → `SYNC` high one cycle.
- 1 Hz: 60 VS falls with `ENABLE`=1 → exactly one `PULSE_1HZ`, on the 60th. With `ENABLE`=0 → none.
- Watchdog:
  - Frame with 65 visible samples at `VIDEO`=512 → `O_SYNC_BAD`=1 after VS fall.
  - Next frame all samples at 0/1023 → `O_SYNC_BAD`=0.
  - Exactly 64 mid samples → 0.
- Macro off: the mid-band frame above → `O_SYNC_BAD` stays 0.
